// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage between decode and execute.
// Accepts decoded instructions (in_*), tracks pending destination writes in a
// 32-entry scoreboard, stalls on RAW/WAW hazards, drives the register-file
// read ports (rf_addr1/2, rf_rd1/2) and presents the operand bundle (out_*)
// one cycle after accept. Writebacks (wb_*) drive the register-file write
// port (rf_addr3, rf_wr1, rf_wr_data) and clear scoreboard bits.
// sb_busy exposes the scoreboard; wb_err flags writebacks to idle registers.
module operand_fetch #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_wen,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [4:0]        out_rd,
  output logic              out_rd_wen,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [4:0]        rf_addr1,
  output logic [4:0]        rf_addr2,
  output logic [4:0]        rf_addr3,
  output logic              rf_rd1,
  output logic              rf_rd2,
  output logic              rf_wr1,
  output logic [XLEN-1:0]   rf_wr_data,
  input  logic [XLEN-1:0]   rf_rd_data1,
  input  logic [XLEN-1:0]   rf_rd_data2,
  output logic [31:0]       sb_busy,
  output logic              wb_err
);

  localparam int unsigned NREG = 32;

  typedef enum logic {IDLE, OUT} state_t;

  state_t            r_state;
  logic [NREG-1:0]   r_sb_busy;
  logic              r_wb_err;
  logic [4:0]        r_out_rd;
  logic              r_out_rd_wen;
  logic [CTRL_W-1:0] r_out_ctrl;

  logic [NREG-1:0]   w_clr;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_pend;
  logic [NREG-1:0]   w_sb_next;
  logic              w_hazard;
  logic              w_accept;

  // One-hot scoreboard clear from writeback and set from an accepted writer
  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (wb_valid) w_clr[wb_rd] = 1'b1;
    if (w_accept && in_rd_wen && (in_rd != 5'd0)) w_set[in_rd] = 1'b1;
  end

  // A writeback landing this cycle already resolves its hazard (RF bypass)
  assign w_pend   = r_sb_busy & ~w_clr;
  assign w_hazard = ((in_rs1 != 5'd0) && w_pend[in_rs1]) ||
                    ((in_rs2 != 5'd0) && w_pend[in_rs2]) ||
                    (in_rd_wen && (in_rd != 5'd0) && w_pend[in_rd]);

  assign in_ready = !w_hazard && ((r_state == IDLE) || out_ready);
  assign w_accept = in_valid && in_ready;

  // Set wins over clear on the same bit; x0 is never tracked
  assign w_sb_next = {(w_pend[NREG-1:1] | w_set[NREG-1:1]), 1'b0};

  // Reads only on accept so the RF holds its data while a bundle is held
  assign rf_addr1 = in_rs1;
  assign rf_addr2 = in_rs2;
  assign rf_rd1   = w_accept;
  assign rf_rd2   = w_accept;

  // Idle write address is 0 so the RF bypass comparator never hits a live read
  assign rf_wr1     = wb_valid;
  assign rf_addr3   = wb_valid ? wb_rd : 5'd0;
  assign rf_wr_data = wb_data;

  assign out_valid   = (r_state == OUT);
  assign out_rs1_val = rf_rd_data1;
  assign out_rs2_val = rf_rd_data2;
  assign out_rd      = r_out_rd;
  assign out_rd_wen  = r_out_rd_wen;
  assign out_ctrl    = r_out_ctrl;
  assign sb_busy     = r_sb_busy;
  assign wb_err      = r_wb_err;

  // State, scoreboard, captured bundle fields and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sb_busy    <= '0;
      r_wb_err     <= 1'b0;
      r_out_rd     <= 5'd0;
      r_out_rd_wen <= 1'b0;
      r_out_ctrl   <= '0;
    end else begin
      r_sb_busy <= w_sb_next;
      if (wb_valid && (wb_rd != 5'd0) && !r_sb_busy[wb_rd]) r_wb_err <= 1'b1;
      if (w_accept) begin
        r_state      <= OUT;
        r_out_rd     <= in_rd;
        r_out_rd_wen <= in_rd_wen;
        r_out_ctrl   <= in_ctrl;
      end else if ((r_state == OUT) && out_ready) begin
        r_state <= IDLE;
      end
    end
  end

endmodule
